// File: rtl/neuron_mac_sequencer.sv
// neuron_mac_sequencer
// Streams one neuron's activation/weight pairs from two synchronous-read
// memories into an external pipelined fixed-point multiplier. It accumulates
// the returned products with saturation, adds the bias, clamps the sum to
// DATA_WIDTH and pulses done_out alongside the registered result.
module neuron_mac_sequencer #(
  parameter int DATA_WIDTH           = 16,
  parameter int FIXED_POINT_POSITION = 10,
  parameter int NUM_INPUTS           = 8,
  parameter int ADDR_WIDTH           = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1,
  parameter int MULT_LATENCY         = 3,
  parameter int ACC_WIDTH            = 32
) (
  input  logic                    clk_in,
  input  logic                    rst_in,
  input  logic                    start_in,
  input  logic [DATA_WIDTH-1:0]   bias_in,
  output logic [ADDR_WIDTH-1:0]   data_addr_out,
  output logic [ADDR_WIDTH-1:0]   weight_addr_out,
  input  logic [DATA_WIDTH-1:0]   data_in,
  input  logic [DATA_WIDTH-1:0]   weight_in,
  output logic [DATA_WIDTH-1:0]   multiplicand_out,
  output logic [DATA_WIDTH-1:0]   multiplier_out,
  input  logic [2*DATA_WIDTH-1:0] product_in,
  output logic                    busy_out,
  output logic                    done_out,
  output logic [DATA_WIDTH-1:0]   result_out,
  output logic                    overflow_out
);

  // Slot tags: stage 0 = read data valid, stage 1 = operands valid,
  // last stage = matching product present on product_in.
  localparam int PIPE_DEPTH = 2 + MULT_LATENCY;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(NUM_INPUTS - 1);
  localparam logic [ACC_WIDTH-1:0]  ACC_MAX   = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic [ACC_WIDTH-1:0]  ACC_MIN   = {1'b1, {(ACC_WIDTH-1){1'b0}}};
  localparam logic [DATA_WIDTH-1:0] DATA_MAX  = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  localparam logic [DATA_WIDTH-1:0] DATA_MIN  = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  // Reject parameter sets the datapath cannot represent.
  if (ACC_WIDTH < 2*DATA_WIDTH || NUM_INPUTS < 1 ||
      FIXED_POINT_POSITION < 0 || FIXED_POINT_POSITION >= DATA_WIDTH) begin : g_bad_params
    $error("neuron_mac_sequencer: illegal parameter combination");
  end

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, FINISH} state_t;

  state_t                  state_reg;
  logic [ADDR_WIDTH-1:0]   addr_reg;
  logic                    vld_reg [PIPE_DEPTH];
  logic [DATA_WIDTH-1:0]   mcand_reg;
  logic [DATA_WIDTH-1:0]   mplier_reg;
  logic [DATA_WIDTH-1:0]   bias_reg;
  logic [DATA_WIDTH-1:0]   result_reg;
  logic [ACC_WIDTH-1:0]    acc_reg;
  logic                    acc_ovf_reg;
  logic                    busy_reg;
  logic                    done_reg;
  logic                    ovf_out_reg;

  logic                    issue_now;
  logic [ACC_WIDTH:0]      acc_ext;
  logic [ACC_WIDTH:0]      prod_ext;
  logic [ACC_WIDTH:0]      acc_sum;
  logic                    acc_sum_ovf;
  logic [ACC_WIDTH:0]      bias_ext;
  logic [ACC_WIDTH:0]      fin_sum;
  logic                    fin_fits;
  logic [DATA_WIDTH-1:0]   fin_sat;

  assign issue_now = (state_reg == ISSUE);

  // One extra bit of headroom so a single add never wraps before the clamp.
  assign acc_ext     = {acc_reg[ACC_WIDTH-1], acc_reg};
  assign prod_ext    = {{(ACC_WIDTH+1-2*DATA_WIDTH){product_in[2*DATA_WIDTH-1]}}, product_in};
  assign acc_sum     = acc_ext + prod_ext;
  assign acc_sum_ovf = acc_sum[ACC_WIDTH] ^ acc_sum[ACC_WIDTH-1];

  // The final sum fits DATA_WIDTH only when all bits above the result sign agree.
  assign bias_ext = {{(ACC_WIDTH+1-DATA_WIDTH){bias_reg[DATA_WIDTH-1]}}, bias_reg};
  assign fin_sum  = acc_ext + bias_ext;
  assign fin_fits = (&fin_sum[ACC_WIDTH:DATA_WIDTH-1]) | ~(|fin_sum[ACC_WIDTH:DATA_WIDTH-1]);
  assign fin_sat  = fin_fits ? fin_sum[DATA_WIDTH-1:0]
                             : (fin_sum[ACC_WIDTH] ? DATA_MIN : DATA_MAX);

  genvar gi;
  generate
    for (gi = 0; gi < PIPE_DEPTH; gi++) begin : g_vld
      if (gi == 0) begin : g_head
        // Tag a slot for every address issued.
        always_ff @(posedge clk_in) begin
          if (rst_in) vld_reg[gi] <= 1'b0;
          else        vld_reg[gi] <= issue_now;
        end
      end else begin : g_tail
        // Walk the tag forward in step with the data/multiplier pipeline.
        always_ff @(posedge clk_in) begin
          if (rst_in) vld_reg[gi] <= 1'b0;
          else        vld_reg[gi] <= vld_reg[gi-1];
        end
      end
    end
  endgenerate

  // Register memory read data as multiplier operands; hold when no slot is valid.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      mcand_reg  <= '0;
      mplier_reg <= '0;
    end else if (vld_reg[0]) begin
      mcand_reg  <= data_in;
      mplier_reg <= weight_in;
    end
  end

  // Saturating accumulation of tagged products; cleared on an accepted start.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      acc_reg     <= '0;
      acc_ovf_reg <= 1'b0;
    end else if (state_reg == IDLE && start_in) begin
      acc_reg     <= '0;
      acc_ovf_reg <= 1'b0;
    end else if (vld_reg[PIPE_DEPTH-1]) begin
      if (acc_sum_ovf) begin
        acc_reg     <= acc_sum[ACC_WIDTH] ? ACC_MIN : ACC_MAX;
        acc_ovf_reg <= 1'b1;
      end else begin
        acc_reg     <= acc_sum[ACC_WIDTH-1:0];
      end
    end
  end

  // Run sequencing with registered address, status and result outputs.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_reg   <= IDLE;
      addr_reg    <= '0;
      bias_reg    <= '0;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
      result_reg  <= '0;
      ovf_out_reg <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          addr_reg <= '0;
          if (start_in) begin
            bias_reg  <= bias_in;
            busy_reg  <= 1'b1;
            state_reg <= ISSUE;
          end
        end
        ISSUE: begin
          if (addr_reg == LAST_ADDR) begin
            addr_reg  <= '0;
            state_reg <= DRAIN;
          end else begin
            addr_reg  <= addr_reg + 1'b1;
          end
        end
        DRAIN: begin
          // Tags form one contiguous burst, so a valid head with an empty
          // stage behind it is the final product of the run.
          if (vld_reg[PIPE_DEPTH-1] && !vld_reg[PIPE_DEPTH-2]) state_reg <= FINISH;
        end
        FINISH: begin
          result_reg  <= fin_sat;
          ovf_out_reg <= acc_ovf_reg | ~fin_fits;
          done_reg    <= 1'b1;
          busy_reg    <= 1'b0;
          state_reg   <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign data_addr_out    = addr_reg;
  assign weight_addr_out  = addr_reg;
  assign multiplicand_out = mcand_reg;
  assign multiplier_out   = mplier_reg;
  assign busy_out         = busy_reg;
  assign done_out         = done_reg;
  assign result_out       = result_reg;
  assign overflow_out     = ovf_out_reg;

endmodule

// File: doc/neuron_mac_sequencer.md
Name: neuron_mac_sequencer

Overview:
- Sequences one neuron's dot product through the shared pipelined fixed-point multiplier.
- Reads NUM_INPUTS activation/weight pairs from two synchronous-read memories and streams them into the multiplier at one pair per cycle.
- Accumulates the products, adds the bias, saturates the sum to DATA_WIDTH and pulses done.
- Sits between the layer controller (start/done) and the multiplier and memories.

Parameters:
- DATA_WIDTH, 16, signed fixed-point width of activations, weights, bias and result.
- FIXED_POINT_POSITION, 10, fractional bits; must match the multiplier instance.
- NUM_INPUTS, 8, pairs per dot product; minimum 1.
- ADDR_WIDTH, $clog2(NUM_INPUTS) (min 1), memory address width.
- MULT_LATENCY, 3, cycles from operands driven to matching product on product_in.
- ACC_WIDTH, 32, signed accumulator width; must be at least 2*DATA_WIDTH.

Ports:
- clk_in  input  1  clock, rising edge.
- rst_in  input  1  synchronous active-high reset.
- start_in  input  1  begin a dot product; sampled only in IDLE.
- bias_in  input  DATA_WIDTH  signed bias, latched at accepted start.
- data_addr_out  output  ADDR_WIDTH  activation memory address.
- weight_addr_out  output  ADDR_WIDTH  weight memory address, always equal to data_addr_out.
- data_in  input  DATA_WIDTH  activation read data, valid 1 cycle after address.
- weight_in  input  DATA_WIDTH  weight read data, valid 1 cycle after address.
- multiplicand_out  output  DATA_WIDTH  registered activation to the multiplier.
- multiplier_out  output  DATA_WIDTH  registered weight to the multiplier.
- product_in  input  2*DATA_WIDTH  signed product from the multiplier, already shifted right by FIXED_POINT_POSITION.
- busy_out  output  1  high while a run is in progress.
- done_out  output  1  one-cycle pulse when result_out is updated.
- result_out  output  DATA_WIDTH  saturated result; held until the next done.
- overflow_out  output  1  high if any saturation occurred in the last run; updated with done.

Behaviour:
- Reset: every output is 0 and the state is IDLE.
  - The accumulator and the valid pipeline are cleared.
  - Products still in flight in the multiplier when reset is applied are ignored.
- States: IDLE, ISSUE, DRAIN, FINISH.
- IDLE:
  - busy_out=0 and addresses held at 0.
  - When start_in=1, latch bias_in, clear the accumulator and the overflow flag, then go to ISSUE.
- ISSUE:
  - Addresses 0..NUM_INPUTS-1 are issued, one per cycle.
  - After the address NUM_INPUTS-1 cycle, go to DRAIN; addresses return to 0.
- Valid pipeline:
  - Address k issued in cycle t gives data in cycle t+1.
  - multiplicand_out and multiplier_out carry pair k in cycle t+2.
  - The product for pair k is sampled from product_in in cycle t+2+MULT_LATENCY.
  - A shift register of depth 2+MULT_LATENCY tags valid slots; only tagged products are accumulated.
  - Operand outputs hold their last value when no slot is valid.
- Accumulation:
  - acc <= sat_ACC(acc + sign_extend(product_in)).
  - Clamp to the ACC_WIDTH signed range; any clamp sets the internal overflow flag.
- DRAIN: after the last product is accumulated, go to FINISH.
- FINISH:
  - Compute sum = acc + sign_extend(bias).
  - Saturate to DATA_WIDTH: clamp above 0x7FFF to 0x7FFF and below -0x8000 to 0x8000. A clamp sets the overflow flag.
  - Register result_out and overflow_out, pulse done_out, go to IDLE.
- Timing, with start sampled in cycle 0:
  - Address k is issued in cycle 1+k.
  - busy_out is high in cycles 1..NUM_INPUTS+MULT_LATENCY+3.
  - done_out is high in exactly cycle NUM_INPUTS+MULT_LATENCY+4 (cycle 15 with defaults). busy_out=0 in that cycle.
- start_in while busy is ignored, not queued.
- start_in in the done cycle is accepted; back-to-back runs have no idle gap beyond that.
- Reset mid-run: return to IDLE immediately, no done_out, and result_out is cleared to 0.

Test Plan:
- Reset: hold rst_in 2 cycles -> all outputs 0, busy_out=0, and no done_out for 20 cycles without start.
- Unity case: all data=0x0400, all weights=0x0400, bias=0x0000, start in cycle 0 -> addresses 0..7 in cycles 1..8, done_out only in cycle 15, result_out=0x2000, overflow_out=0.
- Signed case: data=0x0800, weights=0xFE00, bias=0x0200 -> result_out=0xE200 (-7.5), overflow_out=0.
- Saturation:
  - data=0x7FFF, weights=0x7FFF, bias=0 -> result_out=0x7FFF, overflow_out=1.
  - data=0x8000, weights=0x7FFF -> result_out=0x8000, overflow_out=1.
  - A following unity run clears overflow_out to 0.
- Start handling:
  - Pulse start_in in cycle 5 of a run -> ignored, exactly one done in cycle 15.
  - Start in cycle 15 -> second done in cycle 30 with the correct result.
- Reset mid-run: assert rst_in in cycle 6 -> no done; the next unity run gives 0x2000 with done 15 cycles after its start.
